// File: rtl/audio_i2s_tx_if.sv
// AXI-Stream sample channel between the oscillator/filter chain and the I2S transmitter.
interface audio_i2s_tx_if #(
    parameter int unsigned SAMPLE_SIZE = 16
);
    logic                   tvalid;
    logic [SAMPLE_SIZE-1:0] tdata;
    logic                   tready;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/audio_i2s_tx.sv
// Mono AXI-Stream sink that serialises each accepted sample onto I2S as an L=R stereo frame,
// with a one-entry holding register and underrun reporting when a frame starts empty.
module audio_i2s_tx #(
    parameter int unsigned SAMPLE_SIZE = 16,
    parameter int unsigned BCLK_DIV    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    audio_i2s_tx_if.slave  s_axis,
    output logic           bclk,
    output logic           lrclk,
    output logic           sdata,
    output logic           underrun
);
    localparam int unsigned FRAME_SLOTS = 2 * SAMPLE_SIZE;
    localparam int unsigned SLOT_W      = $clog2(FRAME_SLOTS);
    localparam int unsigned DIV_W       = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_SLOTS - 1);
    localparam logic [SLOT_W-1:0] LR_FIRST  = SLOT_W'(SAMPLE_SIZE - 1);
    localparam logic [SLOT_W-1:0] LR_LAST   = SLOT_W'(FRAME_SLOTS - 2);

    logic [DIV_W-1:0]       div_cnt, div_cnt_nxt;
    logic [SLOT_W-1:0]      slot, slot_nxt;
    logic [SAMPLE_SIZE-1:0] holding, holding_nxt;
    logic [SAMPLE_SIZE-1:0] shift_q, shift_nxt;
    logic                   holding_valid, holding_valid_nxt;
    logic                   bclk_nxt, lrclk_nxt, sdata_nxt, underrun_nxt;
    logic                   div_tc, fall_evt, frame_load, accept;

    // Next-state logic: divider, slot sequencing, frame load and holding-register handshake
    always_comb begin
        div_tc            = (div_cnt == DIV_LAST);
        fall_evt          = div_tc & bclk;
        accept            = s_axis.tvalid & s_axis.tready;
        frame_load        = 1'b0;
        div_cnt_nxt       = div_tc ? '0 : div_cnt + DIV_W'(1);
        bclk_nxt          = div_tc ? ~bclk : bclk;
        slot_nxt          = slot;
        shift_nxt         = shift_q;
        lrclk_nxt         = lrclk;
        sdata_nxt         = sdata;
        underrun_nxt      = 1'b0;
        holding_nxt       = holding;
        holding_valid_nxt = holding_valid;

        if (fall_evt) begin
            frame_load = (slot == SLOT_LAST);
            slot_nxt   = frame_load ? '0 : slot + SLOT_W'(1);
            if (frame_load) begin
                shift_nxt         = holding_valid ? holding : '0;
                underrun_nxt      = ~holding_valid;
                holding_valid_nxt = 1'b0;
            end else begin
                // Rotate so the right channel replays the same word MSB first
                shift_nxt = {shift_q[SAMPLE_SIZE-2:0], shift_q[SAMPLE_SIZE-1]};
            end
            sdata_nxt = shift_nxt[SAMPLE_SIZE-1];
            // Word select leads the data by one slot
            lrclk_nxt = (slot_nxt >= LR_FIRST) && (slot_nxt <= LR_LAST);
        end

        // A beat taken on a load edge is queued for the following frame
        if (accept) begin
            holding_nxt       = s_axis.tdata;
            holding_valid_nxt = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt       <= '0;
            slot          <= SLOT_LAST;
            holding       <= '0;
            holding_valid <= 1'b0;
            shift_q       <= '0;
            bclk          <= 1'b0;
            lrclk         <= 1'b0;
            sdata         <= 1'b0;
            underrun      <= 1'b0;
            s_axis.tready <= 1'b0;
        end else begin
            div_cnt       <= div_cnt_nxt;
            slot          <= slot_nxt;
            holding       <= holding_nxt;
            holding_valid <= holding_valid_nxt;
            shift_q       <= shift_nxt;
            bclk          <= bclk_nxt;
            lrclk         <= lrclk_nxt;
            sdata         <= sdata_nxt;
            underrun      <= underrun_nxt;
            s_axis.tready <= ~holding_valid_nxt;
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: time-based reference model, I2S deserialiser and a BCLK_DIV=1 instance.
module tb_audio_i2s_tx;
    localparam int unsigned N          = 16;
    localparam int unsigned B          = 4;
    localparam int unsigned FRAME_CLKS = 4 * B * N;
    localparam int unsigned NV         = 6;

    typedef struct {
        logic [N-1:0] sample;
        logic [N-1:0] exp_l;
        logic [N-1:0] exp_r;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, reset1_n;
    logic bclk, lrclk, sdata, underrun;
    logic bclk1, lrclk1, sdata1, underrun1;

    audio_i2s_tx_if #(.SAMPLE_SIZE(N)) axis ();
    audio_i2s_tx_if #(.SAMPLE_SIZE(N)) axis1 ();

    audio_i2s_tx #(.SAMPLE_SIZE(N), .BCLK_DIV(B)) dut (
        .clk(clk), .reset_n(reset_n), .s_axis(axis),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
    );

    audio_i2s_tx #(.SAMPLE_SIZE(N), .BCLK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset1_n), .s_axis(axis1),
        .bclk(bclk1), .lrclk(lrclk1), .sdata(sdata1), .underrun(underrun1)
    );

    int n_vectors = 0;
    int n_miscompares = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything derived from clocks elapsed since reset release
    int           t = 0;
    int           cur_slot = -1;
    logic         hold_full = 1'b0;
    logic [N-1:0] hold_val = '0;
    logic [N-1:0] cur_word = '0;
    logic exp_bclk = 1'b0, exp_lr = 1'b0, exp_sd = 1'b0, exp_tready = 1'b0, exp_ur = 1'b0;

    task automatic model_edge();
        logic acc;
        int   k, s;
        if (!reset_n) begin
            t = 0; cur_slot = -1; hold_full = 1'b0; hold_val = '0; cur_word = '0;
            exp_bclk = 1'b0; exp_lr = 1'b0; exp_sd = 1'b0; exp_tready = 1'b0; exp_ur = 1'b0;
            return;
        end
        acc = axis.tvalid && exp_tready;
        t++;
        exp_ur   = 1'b0;
        exp_bclk = ((t / B) % 2) == 1;
        if (t % (2 * B) == 0) begin
            k = t / (2 * B);
            s = (k - 1) % (2 * N);
            if (s == 0) begin
                exp_ur    = !hold_full;
                cur_word  = hold_full ? hold_val : '0;
                hold_full = 1'b0;
            end
            exp_lr   = (s >= N - 1) && (s <= 2 * N - 2);
            exp_sd   = cur_word[N - 1 - (s % N)];
            cur_slot = s;
        end
        if (acc) begin
            hold_full = 1'b1;
            hold_val  = axis.tdata;
        end
        exp_tready = !hold_full;
    endtask

    function automatic logic next_is_load();
        int tn;
        tn = t + 1;
        return (tn % (2 * B) == 0) && (((tn / (2 * B)) - 1) % (2 * N) == 0);
    endfunction

    // I2S deserialiser: a word ends on the bit where lrclk has just changed
    logic           mon_prev_bclk = 1'b0;
    logic           mon_prev_lr = 1'b0;
    logic [N-1:0]   mon_sr = '0;
    logic [N-1:0]   mon_left = '0;
    logic [2*N-1:0] frames[$];
    int             ur_seen = 0;
    int             sd_ones = 0;

    task automatic mon_clear();
        mon_prev_lr = 1'b0;
        mon_sr      = '0;
        frames.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_bit("bclk", bclk, exp_bclk);
        check_bit("lrclk", lrclk, exp_lr);
        check_bit("sdata", sdata, exp_sd);
        check_bit("tready", axis.tready, exp_tready);
        check_bit("underrun", underrun, exp_ur);
        if (underrun === 1'b1) ur_seen++;
        if (sdata === 1'b1) sd_ones++;
        if (bclk === 1'b1 && mon_prev_bclk === 1'b0) begin
            mon_sr = {mon_sr[N-2:0], sdata};
            if (lrclk !== mon_prev_lr) begin
                if (mon_prev_lr === 1'b0) mon_left = mon_sr;
                else frames.push_back({mon_left, mon_sr});
            end
            mon_prev_lr = lrclk;
        end
        mon_prev_bclk = bclk;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        mon_clear();
        for (int i = 0; i < cycles; i++) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_frames(input int want, input int budget);
        int guard;
        guard = 0;
        while (frames.size() < want && guard < budget) begin
            tick();
            guard++;
        end
        check_bit("frames_captured", frames.size() >= want, 1'b1);
    endtask

    vec_t vecs[NV];

    initial begin
        logic           rdy;
        logic           b_prev;
        logic [2*N-1:0] fr;
        int             guard, cnt, k1, s1, f1;

        vecs[0] = '{16'hA5C3, 16'hA5C3, 16'hA5C3};
        vecs[1] = '{16'hA5C3, 16'hA5C3, 16'hA5C3};
        vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[3] = '{16'h8000, 16'h8000, 16'h8000};
        vecs[4] = '{16'h0001, 16'h0001, 16'h0001};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};

        axis.tvalid  = 1'b0;
        axis.tdata   = '0;
        axis1.tvalid = 1'b1;
        axis1.tdata  = 16'h0001;
        reset1_n     = 1'b0;

        // Reset then idle: zero frames, one underrun per frame
        do_reset(4);
        ur_seen = 0;
        sd_ones = 0;
        for (int i = 0; i < 3 * int'(FRAME_CLKS); i++) tick();
        check_val("idle_underruns", 32'(ur_seen), 32'd3);
        check_val("idle_sdata_ones", 32'(sd_ones), 32'd0);

        // Table stream: each sample held until accepted, frames must come out in order
        do_reset(2);
        for (int i = 0; i < int'(NV); i++) begin
            axis.tvalid = 1'b1;
            axis.tdata  = vecs[i].sample;
            guard = 0;
            do begin
                rdy = axis.tready;
                tick();
                guard++;
            end while (!rdy && guard < 2 * int'(FRAME_CLKS));
            check_bit("stream_accept", rdy, 1'b1);
        end
        axis.tvalid = 1'b0;
        wait_frames(NV, (NV + 2) * FRAME_CLKS);
        for (int i = 0; i < int'(NV); i++) begin
            fr = (i < frames.size()) ? frames[i] : 'x;
            check_val("tbl_left", 32'(fr[2*N-1:N]), 32'(vecs[i].exp_l));
            check_val("tbl_right", 32'(fr[N-1:0]), 32'(vecs[i].exp_r));
        end

        // Random traffic against the model, sparse enough to mix data and underrun frames
        for (int i = 0; i < 6 * int'(FRAME_CLKS); i++) begin
            axis.tvalid = ($urandom_range(0, 7) == 0);
            axis.tdata  = N'($urandom);
            tick();
        end

        // Beat offered exactly on a load edge with the holding register empty
        axis.tvalid = 1'b0;
        guard = 0;
        while (!(exp_tready && next_is_load()) && guard < 3 * int'(FRAME_CLKS)) begin
            tick();
            guard++;
        end
        frames.delete();
        axis.tvalid = 1'b1;
        axis.tdata  = 16'h1234;
        tick();
        check_bit("load_beat_underrun", underrun, 1'b1);
        axis.tvalid = 1'b0;
        wait_frames(2, 3 * FRAME_CLKS);
        fr = (frames.size() > 0) ? frames[0] : 'x;
        check_val("load_beat_zero_frame", fr, 32'h0000_0000);
        fr = (frames.size() > 1) ? frames[1] : 'x;
        check_val("load_beat_next_frame", fr, 32'h1234_1234);

        // Reset mid-frame at slot 10, then time the first fall event
        axis.tvalid = 1'b1;
        axis.tdata  = 16'hBEEF;
        guard = 0;
        while (cur_slot != 10 && guard < 2 * int'(FRAME_CLKS)) begin
            tick();
            guard++;
        end
        check_val("reached_slot10", 32'(cur_slot), 32'd10);
        axis.tvalid = 1'b0;
        reset_n = 1'b0;
        mon_clear();
        tick();
        check_bit("midrst_bclk", bclk, 1'b0);
        check_bit("midrst_lrclk", lrclk, 1'b0);
        check_bit("midrst_sdata", sdata, 1'b0);
        check_bit("midrst_tready", axis.tready, 1'b0);
        reset_n = 1'b1;
        cnt = 0;
        b_prev = bclk;
        do begin
            b_prev = bclk;
            tick();
            cnt++;
        end while (!(b_prev === 1'b1 && bclk === 1'b0) && cnt < 4 * int'(B));
        check_val("first_fall_clks", 32'(cnt), 32'(2 * B));
        for (int i = 0; i < int'(FRAME_CLKS); i++) tick();

        // BCLK_DIV=1 instance: 0x0001 stream; first frame is an underrun frame
        reset1_n = 1'b1;
        for (int t1 = 1; t1 <= 200; t1++) begin
            tick();
            k1 = t1 / 2;
            s1 = (k1 >= 1) ? (k1 - 1) % (2 * int'(N)) : -1;
            f1 = (k1 >= 1) ? (k1 - 1) / (2 * int'(N)) : -1;
            check_bit("div1_bclk", bclk1, (t1 % 2) == 1);
            check_bit("div1_sdata", sdata1, (f1 >= 1) && (s1 == 15 || s1 == 31));
            check_bit("div1_lrclk", lrclk1, (s1 >= 15) && (s1 <= 30));
            check_bit("div1_underrun", underrun1, t1 == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
